// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic {UNCFG, RUN} det_state_e;

    // cfg_len must also encode MAX_LEN itself, hence the extra bit.
    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Config, serial data and status bundle of the pattern detector.
interface seq_pattern_detector_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) ();
    localparam int LEN_W = len_w(MAX_LEN);

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               x;
    logic               x_valid;
    logic               y;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;
    logic               armed;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, x, x_valid,
        input  y, match_cnt, cfg_err, armed
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, x, x_valid,
        output y, match_cnt, cfg_err, armed
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !(&cnt_q))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    seq_pattern_detector_if.slave  bus
);
    localparam int LEN_W = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN:0] ONE = {{MAX_LEN{1'b0}}, 1'b1};

    det_state_e         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               y_q, y_d;
    logic               err_q, err_d;

    logic               cfg_ok;
    logic               cfg_bad;
    logic               accept;
    logic               match;
    logic               cnt_clr;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;

    assign cfg_ok  = bus.cfg_we && (bus.cfg_len != '0)
                     && (bus.cfg_len <= MAX_L);
    assign cfg_bad = bus.cfg_we && !cfg_ok;
    // Config has priority: a bit arriving with cfg_we is dropped.
    assign accept  = !bus.cfg_we && (state_q == RUN) && bus.x_valid;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        y_d     = 1'b0;
        err_d   = 1'b0;
        match   = 1'b0;
        cnt_clr = 1'b0;
        hist_n  = {hist_q[MAX_LEN-2:0], bus.x};
        fill_n  = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
        mask    = MAX_LEN'((ONE << len_q) - ONE);
        unique case (1'b1)
            cfg_ok: begin
                pat_d   = bus.cfg_pattern;
                len_d   = bus.cfg_len;
                ovl_d   = bus.cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            cfg_bad: begin
                hist_d  = '0;
                fill_d  = '0;
                cnt_clr = 1'b1;
                err_d   = 1'b1;
                state_d = UNCFG;
            end
            accept: begin
                match  = (fill_n >= len_q)
                         && (((hist_n ^ pat_q) & mask) == '0);
                hist_d = hist_n;
                fill_d = (match && !ovl_q) ? '0 : fill_n;
                y_d    = match;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr_i (cnt_clr),
        .inc_i (match),
        .cnt_o (bus.match_cnt)
    );

    assign bus.y       = y_q;
    assign bus.cfg_err = err_q;
    assign bus.armed   = (state_q == RUN);
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scenario bench for seq_pattern_detector with a y scoreboard queue.
module tb_seq_pattern_detector;
    localparam int ML = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    seq_pattern_detector_if #(.MAX_LEN(ML), .CNT_W(CW)) bus ();

    seq_pattern_detector #(.MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_run  = 0;
    int   n_fail = 0;
    logic exp_q[$];
    logic e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                       input logic o);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = o;
        bus.x           = 1'b1;
        bus.x_valid     = 1'b1;
        tick();
        bus.cfg_we  = 1'b0;
        bus.x_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.cfg_we  = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len = '0;
        bus.cfg_overlap = 1'b0;
        bus.x       = 1'b0;
        bus.x_valid = 1'b0;
        tick();
        tick();
        n_run++;
        if (bus.y !== 1'b0 || bus.armed !== 1'b0 ||
            bus.cfg_err !== 1'b0 || bus.match_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: y=%b armed=%b err=%b cnt=%0d want 0",
                     bus.y, bus.armed, bus.cfg_err, bus.match_cnt);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.x       = 1'($urandom_range(0, 1));
            bus.x_valid = 1'b1;
            exp_q.push_back(1'b0);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (bus.y !== e || bus.armed !== 1'b0 ||
                bus.match_cnt !== 2'd0) begin
                n_fail++;
                $display("FAIL uncfg[%0d]: y=%b armed=%b cnt=%0d want %b/0/0",
                         i, bus.y, bus.armed, bus.match_cnt, e);
            end
        end
        bus.x_valid = 1'b0;
    endtask

    task automatic test_101(input logic ovl, input logic [4:0] exp_y,
                            input logic [1:0] exp_cnt);
        logic [4:0] stim;
        stim = 5'b10101;
        cfg(8'b101, 4'd3, ovl);
        n_run++;
        if (bus.armed !== 1'b1 || bus.y !== 1'b0 ||
            bus.match_cnt !== 2'd0 || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg101 ovl=%b: armed=%b y=%b cnt=%0d err=%b",
                     ovl, bus.armed, bus.y, bus.match_cnt, bus.cfg_err);
        end
        for (int i = 4; i >= 0; i--) begin
            bus.x       = stim[i];
            bus.x_valid = 1'b1;
            exp_q.push_back(exp_y[i]);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (bus.y !== e) begin
                n_fail++;
                $display("FAIL y101 ovl=%b bit%0d: got %b want %b",
                         ovl, 4 - i, bus.y, e);
            end
        end
        bus.x_valid = 1'b0;
        tick();
        n_run++;
        if (bus.y !== 1'b0 || bus.match_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL cnt101 ovl=%b: y=%b cnt=%0d want 0/%0d",
                     ovl, bus.y, bus.match_cnt, exp_cnt);
        end
    endtask

    task automatic test_max_len();
        logic [7:0] p;
        p = 8'hA5;
        cfg(p, 4'd8, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            bus.x       = p[i];
            bus.x_valid = 1'b1;
            exp_q.push_back(i == 0);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (bus.y !== e) begin
                n_fail++;
                $display("FAIL maxlen bit%0d: y=%b want %b", 7 - i, bus.y, e);
            end
            bus.x       = ~p[i];
            bus.x_valid = 1'b0;
            exp_q.push_back(1'b0);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (bus.y !== e) begin
                n_fail++;
                $display("FAIL maxlen gap%0d: y=%b want %b", 7 - i, bus.y, e);
            end
        end
        n_run++;
        if (bus.match_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL maxlen cnt: got %0d want 1", bus.match_cnt);
        end
    endtask

    task automatic test_bad_cfg();
        logic [3:0] lens [2];
        lens[0] = 4'd0;
        lens[1] = 4'd9;
        foreach (lens[k]) begin
            bus.cfg_we      = 1'b1;
            bus.cfg_pattern = 8'h01;
            bus.cfg_len     = lens[k];
            bus.cfg_overlap = 1'b1;
            bus.x_valid     = 1'b0;
            tick();
            bus.cfg_we = 1'b0;
            n_run++;
            if (bus.cfg_err !== 1'b1 || bus.armed !== 1'b0 ||
                bus.y !== 1'b0 || bus.match_cnt !== 2'd0) begin
                n_fail++;
                $display("FAIL badcfg len=%0d: err=%b armed=%b y=%b cnt=%0d",
                         lens[k], bus.cfg_err, bus.armed, bus.y,
                         bus.match_cnt);
            end
            for (int i = 0; i < 3; i++) begin
                bus.x       = 1'b1;
                bus.x_valid = 1'b1;
                exp_q.push_back(1'b0);
                tick();
                e = exp_q.pop_front();
                n_run++;
                if (bus.y !== e || bus.cfg_err !== 1'b0 ||
                    bus.armed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL badcfg len=%0d bit%0d: y=%b err=%b armed=%b",
                             lens[k], i, bus.y, bus.cfg_err, bus.armed);
                end
            end
            bus.x_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want;
        cfg(8'h01, 4'd1, 1'b1);
        n_run++;
        if (bus.y !== 1'b0 || bus.match_cnt !== 2'd0 ||
            bus.armed !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b cfg: y=%b cnt=%0d armed=%b want 0/0/1",
                     bus.y, bus.match_cnt, bus.armed);
        end
        for (int i = 0; i < 6; i++) begin
            bus.x       = 1'b1;
            bus.x_valid = 1'b1;
            exp_q.push_back(1'b1);
            tick();
            e = exp_q.pop_front();
            want = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_run++;
            if (bus.y !== e || bus.match_cnt !== want) begin
                n_fail++;
                $display("FAIL b2b bit%0d: y=%b cnt=%0d want %b/%0d",
                         i, bus.y, bus.match_cnt, e, want);
            end
        end
        reset_n = 1'b0;
        tick();
        n_run++;
        if (bus.y !== 1'b0 || bus.match_cnt !== 2'd0 ||
            bus.armed !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: y=%b cnt=%0d armed=%b err=%b want 0",
                     bus.y, bus.match_cnt, bus.armed, bus.cfg_err);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(1'b0);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (bus.y !== e || bus.armed !== 1'b0) begin
                n_fail++;
                $display("FAIL postreset%0d: y=%b armed=%b want %b/0",
                         i, bus.y, bus.armed, e);
            end
        end
        bus.x_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_101(1'b1, 5'b00101, 2'd2);
        test_101(1'b0, 5'b00100, 2'd1);
        test_max_len();
        test_bad_cfg();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
